// File: rtl/alu_pkg.sv
// Shared ALUOp codes, MIPS opcode/funct constants and the decoded ID/EX entry layout.
// Decoded entries are carried as one packed struct through the skid buffer.
package alu_pkg;

  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_REG_W  = 5;
  localparam int ALU_OP_W     = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b101;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] alu_a;
    logic [ENTRY_DATA_W-1:0] alu_b;
    logic [ALU_OP_W-1:0]     alu_op;
    logic [ENTRY_REG_W-1:0]  wr_reg;
    logic                    wr_en;
    logic                    illegal;
  } entry_t;

  function automatic logic [ENTRY_DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(ENTRY_DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode of instr + register operands into one ALU entry.
// Unknown encodings yield a zeroed entry flagged illegal so it still flows downstream.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]             instr,
  input  logic [ENTRY_DATA_W-1:0] rs_data,
  input  logic [ENTRY_DATA_W-1:0] rt_data,
  output entry_t                  dec
);

  logic [5:0]  opcode;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_rs_idx;

  assign opcode = instr[31:26];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // The rs operand arrives pre-read in rs_data, so its index field is not needed here.
  assign unused_rs_idx = ^instr[25:21];

  always_comb begin
    dec = '0;
    if (opcode == OPC_RTYPE) begin
      dec.wr_reg = rd_idx;
      dec.wr_en  = (rd_idx != 5'd0);
      case (funct)
        FN_ADDU: begin dec.alu_a = rs_data; dec.alu_b = rt_data; dec.alu_op = ALU_ADD; end
        FN_SUBU: begin dec.alu_a = rs_data; dec.alu_b = rt_data; dec.alu_op = ALU_SUB; end
        FN_AND:  begin dec.alu_a = rs_data; dec.alu_b = rt_data; dec.alu_op = ALU_AND; end
        FN_OR:   begin dec.alu_a = rs_data; dec.alu_b = rt_data; dec.alu_op = ALU_OR;  end
        FN_SRL:  begin dec.alu_a = rt_data; dec.alu_b = {27'b0, shamt}; dec.alu_op = ALU_SRL; end
        FN_SRA:  begin dec.alu_a = rt_data; dec.alu_b = {27'b0, shamt}; dec.alu_op = ALU_SRA; end
        // Variable shifts take only rs[4:0] so the ALU never sees an amount >= 32.
        FN_SRLV: begin dec.alu_a = rt_data; dec.alu_b = {27'b0, rs_data[4:0]}; dec.alu_op = ALU_SRL; end
        FN_SRAV: begin dec.alu_a = rt_data; dec.alu_b = {27'b0, rs_data[4:0]}; dec.alu_op = ALU_SRA; end
        default: begin dec = '0; dec.illegal = 1'b1; end
      endcase
    end else begin
      dec.alu_a  = rs_data;
      dec.wr_reg = rt_idx;
      dec.wr_en  = (rt_idx != 5'd0);
      case (opcode)
        OPC_ADDIU: begin dec.alu_b = sext16(imm); dec.alu_op = ALU_ADD; end
        OPC_ANDI:  begin dec.alu_b = {16'b0, imm}; dec.alu_op = ALU_AND; end
        OPC_ORI:   begin dec.alu_b = {16'b0, imm}; dec.alu_op = ALU_OR;  end
        OPC_LUI:   begin dec.alu_a = '0; dec.alu_b = {imm, 16'b0}; dec.alu_op = ALU_OR; end
        OPC_LW:    begin dec.alu_b = sext16(imm); dec.alu_op = ALU_ADD; end
        OPC_SW:    begin dec.alu_b = sext16(imm); dec.alu_op = ALU_ADD; dec.wr_en = 1'b0; end
        default:   begin dec = '0; dec.illegal = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes into ALU operands and registers them in a 2-entry skid buffer.
// One-cycle latency, 1/cycle throughput; in_ready is registered and drops only when the skid entry is full.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic [REG_W-1:0]  wr_reg,
  output logic              wr_en,
  output logic              illegal
);

  generate
    if (DATA_W != ENTRY_DATA_W || REG_W != ENTRY_REG_W) begin : g_bad_width
      $error("alu_issue_stage supports only DATA_W=32, REG_W=5");
    end
  endgenerate

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  entry_t dec;
  entry_t m_ent;
  entry_t s_ent;
  logic   accept;
  logic   consume;

  alu_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .dec     (dec)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      m_ent     <= '0;
      s_ent     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      // Anything accepted this cycle is dropped; a handshake on the output side already completed.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          m_ent     <= dec;
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          if (accept && consume) begin
            m_ent <= dec;
          end else if (accept) begin
            s_ent    <= dec;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (consume) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: if (consume) begin
          m_ent    <= s_ent;
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign alu_a   = m_ent.alu_a;
  assign alu_b   = m_ent.alu_b;
  assign alu_op  = m_ent.alu_op;
  assign wr_reg  = m_ent.wr_reg;
  assign wr_en   = m_ent.wr_en;
  assign illegal = m_ent.illegal;

endmodule
